// File: rtl/mul_wb_buffer_pkg.sv
// rtl/mul_wb_buffer_pkg.sv - shared datapath widths for the multiplier writeback buffer
package mul_wb_buffer_pkg;

  localparam int DEF_WORD_SIZE       = 32;
  localparam int DEF_INSTR_TYPE_SZ   = 4;
  localparam int DEF_ROB_ENTRY_WIDTH = 5;
  localparam int DEF_WB_DEPTH        = 2;

endpackage

// File: rtl/mul_wb_buffer_if.sv
// rtl/mul_wb_buffer_if.sv - upstream M-stage and ROB write-port signal bundle
interface mul_wb_buffer_if
  import mul_wb_buffer_pkg::*;
#(
  parameter int WORD_SIZE       = DEF_WORD_SIZE,
  parameter int INSTR_TYPE_SZ   = DEF_INSTR_TYPE_SZ,
  parameter int ROB_ENTRY_WIDTH = DEF_ROB_ENTRY_WIDTH,
  parameter int DEPTH           = DEF_WB_DEPTH
) ();

  logic                       flush;
  logic                       valid_in;
  logic [INSTR_TYPE_SZ-1:0]   instruction_type_in;
  logic [WORD_SIZE-1:0]       pc_in;
  logic [WORD_SIZE-1:0]       result_in;
  logic [ROB_ENTRY_WIDTH-1:0] rob_id_in;
  logic                       stall;
  logic                       rob_wr_valid;
  logic                       rob_wr_ready;
  logic [INSTR_TYPE_SZ-1:0]   rob_wr_type;
  logic [WORD_SIZE-1:0]       rob_wr_pc;
  logic [WORD_SIZE-1:0]       rob_wr_value;
  logic [ROB_ENTRY_WIDTH-1:0] rob_wr_id;
  logic [$clog2(DEPTH):0]     occupancy;

  // Pipeline/ROB side: drives the upstream entry, flush and the ROB grant.
  modport master (
    output flush, valid_in, instruction_type_in, pc_in, result_in, rob_id_in, rob_wr_ready,
    input  stall, rob_wr_valid, rob_wr_type, rob_wr_pc, rob_wr_value, rob_wr_id, occupancy
  );

  // Buffer side.
  modport slave (
    input  flush, valid_in, instruction_type_in, pc_in, result_in, rob_id_in, rob_wr_ready,
    output stall, rob_wr_valid, rob_wr_type, rob_wr_pc, rob_wr_value, rob_wr_id, occupancy
  );

endinterface

// File: rtl/mul_wb_buffer_sync_fifo.sv
// rtl/mul_wb_buffer_sync_fifo.sv - generic flushable in-order FIFO
module mul_wb_buffer_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push_valid,
  input  logic [WIDTH-1:0]         push_data,
  output logic                     full,
  output logic                     pop_valid,
  input  logic                     pop_ready,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    head;
  logic [AW-1:0]    tail;
  logic             push;
  logic             pop;

  // Flush masks both sides; a full buffer refuses pushes even when popping.
  always_comb begin
    full      = (count == CW'(DEPTH));
    pop_valid = (count != '0);
    push      = push_valid && !full && !flush;
    pop       = pop_valid && pop_ready && !flush;
    pop_data  = mem[head];
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + AW'(1);
      if (pop)  head <= head + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // Payload storage; flush leaves contents in place, only reset clears them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[tail] <= push_data;
    end
  end

endmodule

// File: rtl/mul_wb_buffer.sv
// rtl/mul_wb_buffer.sv - multiplier writeback buffer feeding the ROB write port
module mul_wb_buffer
  import mul_wb_buffer_pkg::*;
#(
  parameter int WORD_SIZE       = DEF_WORD_SIZE,
  parameter int INSTR_TYPE_SZ   = DEF_INSTR_TYPE_SZ,
  parameter int ROB_ENTRY_WIDTH = DEF_ROB_ENTRY_WIDTH,
  parameter int DEPTH           = DEF_WB_DEPTH
) (
  input logic             clk,
  input logic             reset,
  mul_wb_buffer_if.slave  bus
);

  localparam int PAYLOAD_W = INSTR_TYPE_SZ + 2 * WORD_SIZE + ROB_ENTRY_WIDTH;

  logic [PAYLOAD_W-1:0] push_data;
  logic [PAYLOAD_W-1:0] head_data;
  logic                 full;
  logic                 head_valid;

  assign push_data = {bus.instruction_type_in, bus.pc_in, bus.result_in, bus.rob_id_in};

  mul_wb_buffer_sync_fifo #(
    .WIDTH (PAYLOAD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush      (bus.flush),
    .push_valid (bus.valid_in),
    .push_data  (push_data),
    .full       (full),
    .pop_valid  (head_valid),
    .pop_ready  (bus.rob_wr_ready),
    .pop_data   (head_data),
    .count      (bus.occupancy)
  );

  // Stall comes straight from registered occupancy, so no path from rob_wr_ready.
  always_comb begin
    bus.stall        = full;
    bus.rob_wr_valid = head_valid;
    {bus.rob_wr_type, bus.rob_wr_pc, bus.rob_wr_value, bus.rob_wr_id} = head_data;
  end

endmodule

// File: tb/tb_mul_wb_buffer.sv
// tb/tb_mul_wb_buffer.sv - randomized and directed checks against a queue model
module tb_mul_wb_buffer;

  localparam int WS    = 32;
  localparam int TS    = 4;
  localparam int RS    = 5;
  localparam int DEPTH = 2;

  typedef struct {
    logic [TS-1:0] t;
    logic [WS-1:0] pc;
    logic [WS-1:0] val;
    logic [RS-1:0] id;
  } entry_t;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;
  bit   cmp_en;
  entry_t model_q[$];
  int     retired_ids[$];

  mul_wb_buffer_if #(.WORD_SIZE(WS), .INSTR_TYPE_SZ(TS), .ROB_ENTRY_WIDTH(RS), .DEPTH(DEPTH)) bus ();

  mul_wb_buffer #(.WORD_SIZE(WS), .INSTR_TYPE_SZ(TS), .ROB_ENTRY_WIDTH(RS), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: a queue of accepted entries, updated from the rules.
  always @(posedge reset) model_q.delete();

  always @(posedge clk) begin
    if (!reset) begin
      bit do_push, do_pop;
      entry_t e;
      do_push = bus.valid_in && (model_q.size() != DEPTH) && !bus.flush;
      do_pop  = (model_q.size() != 0) && bus.rob_wr_ready && !bus.flush;
      if (bus.rob_wr_valid && bus.rob_wr_ready && !bus.flush) retired_ids.push_back(int'(bus.rob_wr_id));
      if (bus.flush) model_q.delete();
      if (do_pop) void'(model_q.pop_front());
      if (do_push) begin
        e.t = bus.instruction_type_in; e.pc = bus.pc_in; e.val = bus.result_in; e.id = bus.rob_id_in;
        model_q.push_back(e);
      end
    end
  end

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("occupancy", 64'(bus.occupancy), 64'(model_q.size()));
      chk("rob_wr_valid", 64'(bus.rob_wr_valid), 64'(model_q.size() != 0));
      chk("stall", 64'(bus.stall), 64'(model_q.size() == DEPTH));
      if (model_q.size() != 0) begin
        chk("head_type", 64'(bus.rob_wr_type), 64'(model_q[0].t));
        chk("head_pc", 64'(bus.rob_wr_pc), 64'(model_q[0].pc));
        chk("head_value", 64'(bus.rob_wr_value), 64'(model_q[0].val));
        chk("head_id", 64'(bus.rob_wr_id), 64'(model_q[0].id));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic v, input logic [RS-1:0] id);
    bus.valid_in            = v;
    bus.rob_id_in           = id;
    bus.instruction_type_in = TS'($urandom);
    bus.pc_in               = $urandom;
    bus.result_in           = $urandom;
  endtask

  initial begin
    int i, budget;
    bit acc;
    n_checks = 0; n_pass = 0; cmp_en = 0;
    reset = 1'b1;
    bus.flush = 0; bus.valid_in = 0; bus.rob_wr_ready = 0;
    bus.instruction_type_in = '0; bus.pc_in = '0; bus.result_in = '0; bus.rob_id_in = '0;
    tick(); tick();
    chk("reset_valid", 64'(bus.rob_wr_valid), 64'd0);
    chk("reset_stall", 64'(bus.stall), 64'd0);
    chk("reset_occ", 64'(bus.occupancy), 64'd0);
    chk("reset_payload", 64'(bus.rob_wr_value), 64'd0);
    reset = 1'b0;
    cmp_en = 1;

    // Single entry: latency one edge, retires on the next.
    bus.valid_in = 1; bus.pc_in = 32'h100; bus.result_in = 32'h2A; bus.rob_id_in = 3;
    bus.instruction_type_in = 4'h1; bus.rob_wr_ready = 1;
    tick();
    bus.valid_in = 0;
    chk("t1_valid", 64'(bus.rob_wr_valid), 64'd1);
    chk("t1_value", 64'(bus.rob_wr_value), 64'h2A);
    chk("t1_id", 64'(bus.rob_wr_id), 64'd3);
    tick();
    chk("t1_drained_valid", 64'(bus.rob_wr_valid), 64'd0);
    chk("t1_drained_occ", 64'(bus.occupancy), 64'd0);

    // Fill to full with ready low; third entry must be held off.
    bus.rob_wr_ready = 0;
    present(1, 1); tick();
    present(1, 2); tick();
    chk("t2_stall", 64'(bus.stall), 64'd1);
    present(1, 3); tick();
    chk("t2_occ_full", 64'(bus.occupancy), 64'd2);
    chk("t2_head1", 64'(bus.rob_wr_id), 64'd1);
    bus.rob_wr_ready = 1; tick();
    chk("t2_head2", 64'(bus.rob_wr_id), 64'd2);
    chk("t2_unstall", 64'(bus.stall), 64'd0);
    tick();
    bus.valid_in = 0;
    chk("t2_head3", 64'(bus.rob_wr_id), 64'd3);
    tick();
    chk("t2_empty", 64'(bus.rob_wr_valid), 64'd0);

    // Simultaneous push and pop at count 1.
    bus.rob_wr_ready = 0;
    present(1, 4); tick();
    present(1, 5); bus.rob_wr_ready = 1; tick();
    bus.valid_in = 0;
    chk("t3_occ", 64'(bus.occupancy), 64'd1);
    chk("t3_head5", 64'(bus.rob_wr_id), 64'd5);
    tick();

    // Flush at count 2 with a concurrent valid.
    bus.rob_wr_ready = 0;
    present(1, 8); tick();
    present(1, 9); tick();
    chk("t4_occ_before", 64'(bus.occupancy), 64'd2);
    present(1, 7); bus.flush = 1; tick();
    bus.flush = 0; bus.valid_in = 0;
    chk("t4_occ", 64'(bus.occupancy), 64'd0);
    chk("t4_valid", 64'(bus.rob_wr_valid), 64'd0);
    chk("t4_stall", 64'(bus.stall), 64'd0);
    bus.rob_wr_ready = 1; tick();
    chk("t4_no_id7", 64'(bus.occupancy), 64'd0);

    // Stream ids 0..15 with ready toggling; upstream holds while stalled.
    retired_ids.delete();
    i = 0; budget = 0;
    while (i < 16 && budget < 200) begin
      if (!bus.valid_in || bus.rob_id_in != RS'(i)) present(1, RS'(i));
      bus.rob_wr_ready = ~bus.rob_wr_ready;
      acc = !bus.stall;
      tick();
      if (acc) i++;
      budget++;
    end
    bus.valid_in = 0; bus.rob_wr_ready = 1;
    budget = 0;
    while (bus.occupancy != 0 && budget < 50) begin tick(); budget++; end
    chk("t5_drained", 64'(bus.occupancy), 64'd0);
    chk("t5_count", 64'(retired_ids.size()), 64'd16);
    for (int k = 0; k < 16 && k < retired_ids.size(); k++) chk("t5_order", 64'(retired_ids[k]), 64'(k));

    // Random traffic including occasional flushes.
    for (int c = 0; c < 300; c++) begin
      present($urandom_range(0, 3) != 0, RS'($urandom));
      bus.rob_wr_ready = $urandom_range(0, 1);
      bus.flush = ($urandom_range(0, 19) == 0);
      tick();
    end
    bus.flush = 0; bus.valid_in = 0; bus.rob_wr_ready = 0;
    tick();

    // Reset mid-cycle with the buffer full.
    bus.flush = 1; tick(); bus.flush = 0;
    present(1, 12); tick();
    present(1, 13); tick();
    bus.valid_in = 0;
    chk("t6_full", 64'(bus.stall), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("t6_async_valid", 64'(bus.rob_wr_valid), 64'd0);
    chk("t6_async_stall", 64'(bus.stall), 64'd0);
    chk("t6_async_occ", 64'(bus.occupancy), 64'd0);
    tick();
    reset = 1'b0;
    present(1, 11); tick();
    bus.valid_in = 0;
    chk("t6_fresh_valid", 64'(bus.rob_wr_valid), 64'd1);
    chk("t6_fresh_id", 64'(bus.rob_wr_id), 64'd11);
    chk("t6_fresh_occ", 64'(bus.occupancy), 64'd1);
    tick();

    cmp_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
